// File: rtl/ara_inval_sequencer.sv
// Buffers Ara write-burst descriptors and expands each one into line-granular
// L1 D-cache invalidation requests on the CVA6 accelerator handshake.
module ara_inval_sequencer #(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned L1LineWidth = 16,
    parameter int unsigned DescDepth   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 desc_valid_i,
    output logic                 desc_ready_o,
    input  logic [AddrWidth-1:0] desc_addr_i,
    input  logic [7:0]           desc_len_i,
    input  logic [2:0]           desc_size_i,
    output logic                 inval_valid_o,
    input  logic                 inval_ready_i,
    output logic [AddrWidth-1:0] inval_addr_o,
    output logic                 desc_done_o,
    output logic                 busy_o
);

    localparam int unsigned LINE_BITS = $clog2(L1LineWidth);
    localparam int unsigned CNT_W     = $clog2((2 ** 15) / L1LineWidth + 2);
    localparam int unsigned PTR_W     = $clog2(DescDepth);
    localparam logic [AddrWidth-1:0] LINE_MASK = ~(AddrWidth'(L1LineWidth - 1));

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t state_q, state_d;

    logic [AddrWidth-1:0] mem_addr [DescDepth];
    logic [7:0]           mem_len  [DescDepth];
    logic [2:0]           mem_size [DescDepth];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       count;
    logic                 full, empty, push, pop;

    logic [AddrWidth-1:0] head_addr;
    logic [7:0]           head_len;
    logic [2:0]           head_size;
    logic [AddrWidth-1:0] size_mask;
    logic [15:0]          burst_bytes;
    logic [AddrWidth:0]   last_byte;
    logic [AddrWidth-1:0] first_line, last_line;
    logic [CNT_W-1:0]     lines_init;

    logic [AddrWidth-1:0] cur_addr;
    logic [CNT_W-1:0]     lines_left;
    logic                 load, advance;

    assign full         = (count == (PTR_W + 1)'(DescDepth));
    assign empty        = (count == '0);
    assign push         = desc_valid_i && !full;
    assign desc_ready_o = !full;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_addr[wr_ptr] <= desc_addr_i;
            mem_len[wr_ptr]  <= desc_len_i;
            mem_size[wr_ptr] <= desc_size_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        end
    end

    assign head_addr = mem_addr[rd_ptr];
    assign head_len  = mem_len[rd_ptr];
    assign head_size = mem_size[rd_ptr];

    // One extra bit catches bursts running past the top of the address space;
    // such bursts stop at the top line instead of wrapping.
    always_comb begin
        size_mask   = ~({AddrWidth{1'b1}} << head_size);
        burst_bytes = ({8'd0, head_len} + 16'd1) << head_size;
        last_byte   = {1'b0, head_addr & ~size_mask}
                    + {{(AddrWidth - 15){1'b0}}, burst_bytes}
                    - {{AddrWidth{1'b0}}, 1'b1};
        first_line  = head_addr & LINE_MASK;
        last_line   = last_byte[AddrWidth] ? LINE_MASK : (last_byte[AddrWidth-1:0] & LINE_MASK);
        lines_init  = CNT_W'((last_line - first_line) >> LINE_BITS);
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        load        = 1'b0;
        advance     = 1'b0;
        desc_done_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (en_i) begin
                        load    = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        desc_done_o = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (inval_ready_i) begin
                    // A low enable ends the descriptor at the line just handshaked.
                    if (lines_left != '0 && en_i) begin
                        advance = 1'b1;
                    end else begin
                        desc_done_o = 1'b1;
                        if (!empty && en_i) begin
                            pop  = 1'b1;
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cur_addr   <= '0;
            lines_left <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                cur_addr   <= first_line;
                lines_left <= lines_init;
            end else if (advance) begin
                cur_addr   <= cur_addr + AddrWidth'(L1LineWidth);
                lines_left <= lines_left - CNT_W'(1);
            end
        end
    end

    assign inval_valid_o = (state_q == ISSUE);
    assign inval_addr_o  = cur_addr;
    assign busy_o        = !empty || (state_q != IDLE);

endmodule
